// File: rtl/switch_event_pkg.sv
// Shared definitions for the switch event controller: event type codes and record layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package switch_event_pkg;

  localparam int EV_TYPE_W = 2;

  localparam logic [EV_TYPE_W-1:0] EV_RELEASE = 2'b00;
  localparam logic [EV_TYPE_W-1:0] EV_PRESS   = 2'b01;
  localparam logic [EV_TYPE_W-1:0] EV_REPEAT  = 2'b10;

  // A queued event is {index, type}; this gives its total width.
  function automatic int ev_rec_w(input int idx_w);
    return idx_w + EV_TYPE_W;
  endfunction

endpackage

// File: rtl/switch_event_ctrl_if.sv
// Event delivery bus from the switch event controller to its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds ev_ready low to stall; head fields stay stable meanwhile.
interface switch_event_ctrl_if #(
  parameter int IDX_W = 3
);
  import switch_event_pkg::*;

  logic                 ev_valid;
  logic                 ev_ready;
  logic [IDX_W-1:0]     ev_index;
  logic [EV_TYPE_W-1:0] ev_type;

  modport master (output ev_valid, output ev_index, output ev_type, input ev_ready);
  modport slave  (input ev_valid, input ev_index, input ev_type, output ev_ready);

endinterface

// File: rtl/switch_event_fifo.sv
// Generic synchronous first-word fall-through FIFO; head data visible whenever not empty.
// Latency: a push is visible at the head one cycle later when the FIFO was empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module switch_event_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  // Storage and pointer update; reset also clears storage so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= push_data;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/switch_event_ctrl.sv
// Debounce sample strobe, press/release/auto-repeat event generation and event queue.
// Latency: a level change in cycle n is queued at the end of n; ev_valid rises in n+1 if empty.
// Backpressure: full queue holds edge changes pending (no loss); a due repeat is dropped and flagged.
module switch_event_ctrl
  import switch_event_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int RATE         = 125000,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int FIFO_DEPTH   = 8,
  parameter int IDX_W        = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     sw_state,
  output logic                 sample_tick,
  switch_event_ctrl_if.master  ev,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int                REC_W    = ev_rec_w(IDX_W);
  localparam int                CNT_W    = $clog2(REPEAT_DELAY + 1);
  localparam logic [23:0]       RATE_C   = 24'(RATE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]  CNT_RELD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [23:0]      presc;
  logic [WIDTH-1:0] rep_lvl;
  logic [WIDTH-1:0] diff;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_lvl;
  logic             edge_push;
  logic             rpt_push;
  logic             rpt_drop;
  logic             push;
  logic [REC_W-1:0] push_data;
  logic [REC_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] rpt_idx;
  logic             rpt_act;
  logic             rpt_pend;
  logic [CNT_W-1:0] rpt_cnt;

  // Prescaler: free-runs 0..RATE while enabled, parked at 0 otherwise so the
  // first enabled cycle produces a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 presc <= '0;
    else if (!enable)        presc <= '0;
    else if (presc == RATE_C) presc <= '0;
    else                     presc <= presc + 24'd1;
  end

  // Strobe is held low while reset is asserted even if enable is already high.
  assign sample_tick = enable & ~rst & (presc == '0);

  assign diff = sw_state ^ rep_lvl;

  // Pick the lowest-index switch whose level differs from what was last reported.
  always_comb begin
    sel_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_lvl   = sw_state[sel_idx];
  assign edge_push = enable & (|diff) & ~fifo_full;
  assign rpt_push  = enable & rpt_pend & ~edge_push & ~fifo_full;
  assign rpt_drop  = enable & rpt_pend & fifo_full;
  assign push      = edge_push | rpt_push;
  assign push_data = edge_push ? {sel_idx, (sel_lvl ? EV_PRESS : EV_RELEASE)}
                               : {rpt_idx, EV_REPEAT};

  // Reported levels: follow each serviced edge; track silently while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rep_lvl <= '0;
    else if (!enable)   rep_lvl <= sw_state;
    else if (edge_push) rep_lvl[sel_idx] <= sel_lvl;
  end

  // Auto-repeat channel: later statements win, so a new press overrides tick counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_idx  <= '0;
      rpt_act  <= 1'b0;
      rpt_pend <= 1'b0;
      rpt_cnt  <= '0;
    end else if (!enable) begin
      rpt_act  <= 1'b0;
      rpt_pend <= 1'b0;
    end else begin
      if (rpt_push || rpt_drop) rpt_pend <= 1'b0;
      if (sample_tick && rpt_act) begin
        if (rpt_cnt == CNT_LAST) begin
          rpt_pend <= 1'b1;
          rpt_cnt  <= CNT_RELD;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
      if (edge_push && sel_lvl) begin
        rpt_idx <= sel_idx;
        rpt_act <= 1'b1;
        rpt_cnt <= '0;
      end else if (edge_push && (sel_idx == rpt_idx)) begin
        rpt_act  <= 1'b0;
        rpt_pend <= 1'b0;
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= rpt_drop | (overflow & ~clr_overflow);
  end

  switch_event_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (ev.ev_ready),
    .pop_data  (head),
    .empty     (fifo_empty)
  );

  assign ev.ev_valid = ~fifo_empty;
  assign ev.ev_index = head[REC_W-1:EV_TYPE_W];
  assign ev.ev_type  = head[EV_TYPE_W-1:0];

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Directed bench for switch_event_ctrl with short prescaler, repeat and queue settings.
// Latency: checks are taken 2 time units after each rising edge, inputs driven 1 unit after.
// Backpressure: ev_ready is driven directly by the scenarios.
module tb_switch_event_ctrl;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;
  localparam logic [1:0] T_REL = 2'b00;
  localparam logic [1:0] T_PRS = 2'b01;
  localparam logic [1:0] T_RPT = 2'b10;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] sw_state;
  logic             sample_tick;
  logic             overflow;
  logic             clr_overflow;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  switch_event_ctrl_if #(.IDX_W(IDX_W)) ev_if ();

  switch_event_ctrl #(
    .WIDTH        (WIDTH),
    .RATE         (3),
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2),
    .FIFO_DEPTH   (4),
    .IDX_W        (IDX_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sw_state     (sw_state),
    .sample_tick  (sample_tick),
    .ev           (ev_if),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; sw_state = 8'h05; ev_if.ev_ready = 1'b1; clr_overflow = 1'b0;
    repeat (3) cyc();
    #1;
    vectors++; if (ev_if.ev_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", ev_if.ev_valid); end
    vectors++; if (ev_if.ev_index !== 3'd0) begin miscompares++; $display("FAIL reset_index got %0d want 0", ev_if.ev_index); end
    vectors++; if (ev_if.ev_type !== T_REL) begin miscompares++; $display("FAIL reset_type got %b want 00", ev_if.ev_type); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    vectors++; if (sample_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b want 0", sample_tick); end
  endtask

  task automatic test_scan();
    cyc(); rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(); #1;
      vectors++;
      if (ev_if.ev_valid !== (k <= 2)) begin miscompares++; $display("FAIL scan_valid k=%0d got %b want %b", k, ev_if.ev_valid, (k <= 2)); end
      if (k <= 2) begin
        vectors++;
        if (ev_if.ev_index !== ((k == 1) ? 3'd0 : 3'd2) || ev_if.ev_type !== T_PRS) begin
          miscompares++; $display("FAIL scan_event k=%0d got %0d/%b want %0d/01", k, ev_if.ev_index, ev_if.ev_type, (k == 1) ? 0 : 2);
        end
      end
    end
    cyc(); enable = 1'b0; sw_state = 8'h00;
  endtask

  task automatic test_prescaler();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(); enable = 1'b0; #1;
      vectors++; if (sample_tick !== 1'b0) begin miscompares++; $display("FAIL tick_disabled k=%0d got %b want 0", k, sample_tick); end
    end
    for (int k = 0; k < 12; k++) begin
      cyc(); enable = 1'b1; #1;
      if (sample_tick === 1'b1) pulses++;
      vectors++; if (sample_tick !== ((k % 4) == 0)) begin miscompares++; $display("FAIL tick_pattern k=%0d got %b want %b", k, sample_tick, ((k % 4) == 0)); end
    end
    vectors++; if (pulses != 3) begin miscompares++; $display("FAIL tick_count got %0d want 3", pulses); end
  endtask

  task automatic test_repeat();
    logic       exp_v;
    logic [1:0] exp_t;
    cyc(); enable = 1'b0; sw_state = 8'h00;
    cyc(); enable = 1'b1; sw_state = 8'h10; #1;
    vectors++; if (sample_tick !== 1'b1) begin miscompares++; $display("FAIL rpt_start_tick got %b want 1", sample_tick); end
    for (int k = 1; k <= 50; k++) begin
      cyc();
      if (k == 31) sw_state = 8'h00;
      #1;
      exp_v = (k == 1) || (k == 14) || (k == 22) || (k == 30) || (k == 32);
      exp_t = (k == 1) ? T_PRS : ((k == 32) ? T_REL : T_RPT);
      vectors++; if (ev_if.ev_valid !== exp_v) begin miscompares++; $display("FAIL rpt_valid k=%0d got %b want %b", k, ev_if.ev_valid, exp_v); end
      if (exp_v) begin
        vectors++;
        if (ev_if.ev_index !== 3'd4 || ev_if.ev_type !== exp_t) begin
          miscompares++; $display("FAIL rpt_event k=%0d got %0d/%b want 4/%b", k, ev_if.ev_index, ev_if.ev_type, exp_t);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    cyc(); enable = 1'b0; sw_state = 8'h00; ev_if.ev_ready = 1'b0;
    cyc(); enable = 1'b1; sw_state = 8'h3F; #1;
    vectors++; if (ev_if.ev_valid !== 1'b0) begin miscompares++; $display("FAIL bp_first got %b want 0", ev_if.ev_valid); end
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 8) ev_if.ev_ready = 1'b1;
      if (k == 14) begin enable = 1'b0; sw_state = 8'h00; end
      #1;
      if (k <= 13) begin
        vectors++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_type !== T_PRS ||
            ev_if.ev_index !== ((k <= 7) ? 3'd0 : 3'(k - 8))) begin
          miscompares++; $display("FAIL bp_head k=%0d got %b/%0d/%b want 1/%0d/01", k, ev_if.ev_valid, ev_if.ev_index, ev_if.ev_type, (k <= 7) ? 0 : k - 8);
        end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL bp_overflow k=%0d got %b want 0", k, overflow); end
      end else begin
        vectors++; if (ev_if.ev_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %b want 0", ev_if.ev_valid); end
      end
    end
  endtask

  task automatic test_overflow();
    logic exp_o;
    cyc(); enable = 1'b0; sw_state = 8'h00; ev_if.ev_ready = 1'b0; clr_overflow = 1'b0;
    cyc(); enable = 1'b1; sw_state = 8'h1D; #1;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_start got %b want 0", overflow); end
    for (int k = 1; k <= 22; k++) begin
      cyc();
      clr_overflow = (k == 14) || (k == 21) || (k == 22);
      #1;
      exp_o = (k == 14) || (k == 22);
      vectors++; if (overflow !== exp_o) begin miscompares++; $display("FAIL ovf_flag k=%0d got %b want %b", k, overflow, exp_o); end
      if (exp_o) begin
        vectors++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_index !== 3'd0) begin
          miscompares++; $display("FAIL ovf_head k=%0d got %b/%0d want 1/0", k, ev_if.ev_valid, ev_if.ev_index);
        end
      end
    end
  endtask

  task automatic test_glitch_and_reset();
    int exp_i [6];
    exp_i = '{0, 2, 3, 4, -1, 4};
    cyc(); clr_overflow = 1'b0; sw_state = 8'h1F; #1;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL glitch_ovf_clear got %b want 0", overflow); end
    cyc(); sw_state = 8'h1D;
    for (int j = 0; j < 6; j++) begin
      cyc();
      ev_if.ev_ready = (j != 5);
      #1;
      vectors++;
      if (exp_i[j] < 0) begin
        if (ev_if.ev_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_gap j=%0d got %b want 0", j, ev_if.ev_valid); end
      end else if (ev_if.ev_valid !== 1'b1 || ev_if.ev_index !== 3'(exp_i[j]) ||
                   ev_if.ev_type !== ((j == 5) ? T_RPT : T_PRS)) begin
        miscompares++; $display("FAIL glitch_head j=%0d got %b/%0d/%b want 1/%0d/%b", j, ev_if.ev_valid, ev_if.ev_index, ev_if.ev_type, exp_i[j], (j == 5) ? T_RPT : T_PRS);
      end
    end
    cyc(); #1;
    vectors++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_index !== 3'd4) begin miscompares++; $display("FAIL hold_head got %b/%0d want 1/4", ev_if.ev_valid, ev_if.ev_index); end
    #2; rst = 1'b1; #1;
    vectors++; if (ev_if.ev_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", ev_if.ev_valid); end
    vectors++; if (ev_if.ev_index !== 3'd0 || ev_if.ev_type !== T_REL) begin miscompares++; $display("FAIL midrst_head got %0d/%b want 0/00", ev_if.ev_index, ev_if.ev_type); end
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_prescaler();
    test_repeat();
    test_backpressure();
    test_overflow();
    test_glitch_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
